// File: rtl/bram_stream_reader_if.sv
// Signal bundle for the BRAM stream reader: command/status, RAM read port and output byte stream.
// The master modport is the reader; the slave modport is the surrounding system (RAM, host, sink).
interface bram_stream_reader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH:0]   length;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_rd;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] stream_data;
    logic                  stream_valid;
    logic                  stream_ready;
    logic                  stream_last;

    modport master (
        input  start, start_addr, length, abort, ram_q, stream_ready,
        output busy, done, ram_addr, ram_rd, stream_data, stream_valid, stream_last
    );

    modport slave (
        output start, start_addr, length, abort, ram_q, stream_ready,
        input  busy, done, ram_addr, ram_rd, stream_data, stream_valid, stream_last
    );
endinterface

// File: rtl/bram_stream_reader.sv
// Sweeps a wrap-around BRAM address range and streams the bytes out with valid/ready/last.
// A credit-limited FIFO absorbs the RAM read latency so backpressure never drops data.
module bram_stream_reader #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    bram_stream_reader_if.master bus
);
    localparam int DEPTH = READ_LATENCY + 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam logic [LEN_W-1:0] MAX_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [LEN_W-1:0]        remaining;
    logic [LEN_W-1:0]        clamped_len;
    logic [ADDR_WIDTH-1:0]   ram_addr_q;
    logic                    ram_rd_q;
    logic                    ram_last_q;
    logic [READ_LATENCY-1:0] tag_valid;
    logic [READ_LATENCY-1:0] tag_last;
    logic [DATA_WIDTH-1:0]   fifo_data [DEPTH];
    logic [DEPTH-1:0]        fifo_last;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic [CNT_W-1:0]        fifo_count;
    logic                    done_q;
    logic                    fifo_empty;
    logic                    head_last;
    logic                    push;
    logic                    pop;
    logic                    credit_ok;
    logic                    accept;
    logic                    issue_more;
    logic                    finish;
    logic                    zero_done;
    logic                    abort_now;
    int                      used;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Credit counts the read on the RAM port now, the tags in flight and the FIFO, minus
    // the byte leaving this cycle, so a steady stream never stalls yet never overflows.
    always_comb begin
        fifo_empty  = (fifo_count == '0);
        head_last   = fifo_last[rd_ptr];
        pop         = !fifo_empty && bus.stream_ready;
        push        = tag_valid[READ_LATENCY-1];
        clamped_len = (bus.length > MAX_LEN) ? MAX_LEN : bus.length;
        used        = int'(fifo_count) + $countones({tag_valid, ram_rd_q}) - int'(pop);
        credit_ok   = used < DEPTH;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue_more = 1'b0;
        finish     = 1'b0;
        zero_done  = 1'b0;
        abort_now  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (clamped_len == '0) begin
                        zero_done = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = (clamped_len == LEN_W'(1)) ? DRAIN : RUN;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    abort_now  = 1'b1;
                    state_next = IDLE;
                end else if (credit_ok) begin
                    issue_more = 1'b1;
                    if (remaining == LEN_W'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (bus.abort) begin
                    abort_now  = 1'b1;
                    state_next = IDLE;
                end else if (pop && head_last) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The first read goes out on the accepting edge; later reads follow the credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining  <= '0;
            ram_addr_q <= '0;
            ram_rd_q   <= 1'b0;
            ram_last_q <= 1'b0;
            tag_valid  <= '0;
            tag_last   <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q   <= finish || zero_done;
            ram_rd_q <= accept || issue_more;
            if (accept) begin
                ram_addr_q <= bus.start_addr;
                ram_last_q <= (clamped_len == LEN_W'(1));
                remaining  <= clamped_len - LEN_W'(1);
            end else if (issue_more) begin
                ram_addr_q <= ram_addr_q + 1'b1;
                ram_last_q <= (remaining == LEN_W'(1));
                remaining  <= remaining - LEN_W'(1);
            end else begin
                ram_last_q <= 1'b0;
            end
            if (abort_now) begin
                tag_valid <= '0;
                tag_last  <= '0;
            end else begin
                tag_valid[0] <= ram_rd_q;
                tag_last[0]  <= ram_last_q;
                for (int i = 1; i < READ_LATENCY; i++) begin
                    tag_valid[i] <= tag_valid[i-1];
                    tag_last[i]  <= tag_last[i-1];
                end
            end
        end
    end

    // Matured tags capture RamQ; an abort drops both queued and late-returning bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            fifo_last  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
            end
        end else if (abort_now) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= bus.ram_q;
                fifo_last[wr_ptr] <= tag_last[READ_LATENCY-1];
                wr_ptr            <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.done         = done_q;
    assign bus.ram_addr     = ram_addr_q;
    assign bus.ram_rd       = ram_rd_q;
    assign bus.stream_valid = !fifo_empty;
    assign bus.stream_data  = fifo_data[rd_ptr];
    assign bus.stream_last  = !fifo_empty && head_last;
endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomised bench for bram_stream_reader: a transfer-level model predicts every byte, address,
// Busy/Done level and stall hold, and a negedge monitor compares the DUT against it each cycle.
module tb_bram_stream_reader;
    localparam int AW     = 10;
    localparam int DW     = 8;
    localparam int RL     = 2;
    localparam int MAXOUT = RL + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    int   ready_mode = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    bram_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Two-stage synchronous RAM: address register gated by ce, then output register.
    logic [DW-1:0] ram_mem [1024];
    logic [DW-1:0] ram_stage;
    always @(posedge clk) begin
        if (bus.ram_rd) ram_stage <= ram_mem[bus.ram_addr];
        bus.ram_q <= ram_stage;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Transfer-level model state, owned by the monitor.
    bit            m_busy, m_done_exp, hold_pending, first_pending, was_busy;
    int            issued, accepted, xfer_len, start_cycle, exp_addr, req_len;
    int            hs_count, done_count;
    logic [DW-1:0] exp_q [$];
    int            addr_log [$];
    logic [DW-1:0] hold_data, first_byte, last_byte;
    logic          hold_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("reset_busy", 32'(bus.busy), 0);
            checkOutput("reset_done", 32'(bus.done), 0);
            checkOutput("reset_ram_rd", 32'(bus.ram_rd), 0);
            checkOutput("reset_ram_addr", 32'(bus.ram_addr), 0);
            checkOutput("reset_valid", 32'(bus.stream_valid), 0);
            checkOutput("reset_last", 32'(bus.stream_last), 0);
            checkOutput("reset_data", 32'(bus.stream_data), 0);
            m_busy = 0; m_done_exp = 0; hold_pending = 0; first_pending = 0;
            exp_q.delete();
        end else begin
            was_busy = m_busy;
            checkOutput("busy", 32'(bus.busy), 32'(m_busy));
            checkOutput("done", 32'(bus.done), 32'(m_done_exp));
            if (bus.done) done_count++;
            m_done_exp = 0;
            if (!m_busy) begin
                checkOutput("idle_valid", 32'(bus.stream_valid), 0);
                checkOutput("idle_ram_rd", 32'(bus.ram_rd), 0);
            end
            if (hold_pending) begin
                checkOutput("stall_valid", 32'(bus.stream_valid), 1);
                checkOutput("stall_data", 32'(bus.stream_data), 32'(hold_data));
                checkOutput("stall_last", 32'(bus.stream_last), 32'(hold_last));
            end
            if (m_busy && bus.ram_rd) begin
                checkOutput("ram_addr", 32'(bus.ram_addr), 32'(exp_addr));
                checkOutput("reads_within_len", 32'(issued < xfer_len), 1);
                addr_log.push_back(int'(bus.ram_addr));
                issued++;
                exp_addr = (exp_addr + 1) % 1024;
                checkOutput("outstanding_le_4", 32'((issued - accepted) <= MAXOUT), 1);
            end
            if (m_busy && first_pending && bus.stream_valid) begin
                checkOutput("first_valid_latency", 32'(cycle - start_cycle), 4);
                first_pending = 0;
            end
            if (m_busy && bus.stream_valid && bus.stream_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extra_byte", 1, 0);
                end else begin
                    checkOutput("data", 32'(bus.stream_data), 32'(exp_q[0]));
                    checkOutput("last", 32'(bus.stream_last), 32'(exp_q.size() == 1));
                    if (hs_count == 0) first_byte = bus.stream_data;
                    last_byte = bus.stream_data;
                    if (exp_q.size() == 1) begin
                        m_busy = 0;
                        m_done_exp = 1;
                    end
                    void'(exp_q.pop_front());
                    accepted++;
                    hs_count++;
                end
            end
            if (was_busy && bus.abort) begin
                m_busy = 0; m_done_exp = 0; first_pending = 0;
                exp_q.delete();
            end
            if (!was_busy && bus.start) begin
                req_len = (int'(bus.length) > 1024) ? 1024 : int'(bus.length);
                hs_count = 0;
                addr_log.delete();
                if (req_len == 0) begin
                    m_done_exp = 1;
                end else begin
                    m_busy = 1; first_pending = 1;
                    xfer_len = req_len; issued = 0; accepted = 0;
                    exp_addr = int'(bus.start_addr); start_cycle = cycle;
                    for (int i = 0; i < req_len; i++)
                        exp_q.push_back(ram_mem[10'((int'(bus.start_addr) + i) % 1024)]);
                end
            end
            hold_pending = m_busy && bus.stream_valid && !bus.stream_ready;
            hold_data    = bus.stream_data;
            hold_last    = bus.stream_last;
        end
    end

    initial begin
        bus.stream_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.stream_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
        end
    end

    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [AW:0] len);
        bus.start = 1'b1; bus.start_addr = addr; bus.length = len;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (!bus.done && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(name, 32'(bus.done), 1);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int dc;
        int n;
        int rl;
        bus.start = 1'b0; bus.start_addr = '0; bus.length = '0; bus.abort = 1'b0;
        for (int i = 0; i < 1024; i++) ram_mem[i] = 8'((i * 37 + 11) & 255);
        settle(3);
        rst_n = 1'b1;
        settle(1);

        // Basic: RAM[0]=0x0B, RAM[15]=0x36
        dc = done_count;
        applyStimulus(10'h000, 11'd16);
        waitDone("basic_done");
        settle(2);
        checkOutput("basic_bytes", 32'(hs_count), 16);
        checkOutput("basic_first", 32'(first_byte), 32'h0B);
        checkOutput("basic_lastbyte", 32'(last_byte), 32'h36);
        checkOutput("basic_done_count", 32'(done_count - dc), 1);

        // Wrap: RAM[0x3FC]=0x77, RAM[3]=0x7A
        applyStimulus(10'h3FC, 11'd8);
        waitDone("wrap_done");
        settle(1);
        checkOutput("wrap_bytes", 32'(hs_count), 8);
        checkOutput("wrap_nreads", 32'(addr_log.size()), 8);
        checkOutput("wrap_addr3", 32'(addr_log[3]), 32'h3FF);
        checkOutput("wrap_addr4", 32'(addr_log[4]), 32'h000);
        checkOutput("wrap_first", 32'(first_byte), 32'h77);
        checkOutput("wrap_lastbyte", 32'(last_byte), 32'h7A);

        // Backpressure at ~30% ready duty
        ready_mode = 1;
        applyStimulus(10'($urandom_range(0, 1023)), 11'd64);
        waitDone("bp_done");
        ready_mode = 0;
        settle(1);
        checkOutput("bp_bytes", 32'(hs_count), 64);

        // Length 0: Done next cycle, no reads
        dc = done_count;
        applyStimulus(10'h123, 11'd0);
        waitDone("len0_done");
        settle(2);
        checkOutput("len0_reads", 32'(addr_log.size()), 0);
        checkOutput("len0_bytes", 32'(hs_count), 0);
        checkOutput("len0_done_count", 32'(done_count - dc), 1);

        // Length 1: RAM[5]=0xC4
        applyStimulus(10'h005, 11'd1);
        waitDone("len1_done");
        settle(1);
        checkOutput("len1_bytes", 32'(hs_count), 1);
        checkOutput("len1_byte", 32'(last_byte), 32'hC4);

        // Length 2000 clamps to a full 1024-byte sweep
        applyStimulus(10'h200, 11'd2000);
        waitDone("len2000_done");
        settle(1);
        checkOutput("len2000_bytes", 32'(hs_count), 1024);

        // Abort after 5 bytes of a 32-byte transfer, then a clean restart
        dc = done_count;
        applyStimulus(10'h040, 11'd32);
        n = 0;
        while (hs_count < 5 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("abort_reach5", 32'(hs_count >= 5), 1);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        checkOutput("abort_busy", 32'(bus.busy), 0);
        checkOutput("abort_valid", 32'(bus.stream_valid), 0);
        settle(6);
        checkOutput("abort_no_done", 32'(done_count - dc), 0);
        applyStimulus(10'h080, 11'd16);
        waitDone("post_abort_done");
        settle(1);
        checkOutput("post_abort_bytes", 32'(hs_count), 16);

        // Reset mid-transfer
        dc = done_count;
        applyStimulus(10'h010, 11'd64);
        settle(10);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_now_busy", 32'(bus.busy), 0);
        checkOutput("rst_now_valid", 32'(bus.stream_valid), 0);
        checkOutput("rst_now_ram_rd", 32'(bus.ram_rd), 0);
        checkOutput("rst_now_data", 32'(bus.stream_data), 0);
        settle(2);
        rst_n = 1'b1;
        settle(6);
        checkOutput("rst_no_done", 32'(done_count - dc), 0);

        // Back-to-back: second Start in the Done cycle
        dc = done_count;
        applyStimulus(10'h020, 11'd8);
        waitDone("b2b_done1");
        applyStimulus(10'h030, 11'd8);
        waitDone("b2b_done2");
        settle(2);
        checkOutput("b2b_bytes", 32'(hs_count), 8);
        checkOutput("b2b_done_count", 32'(done_count - dc), 2);

        // Random contents, addresses, lengths and ready patterns
        for (int i = 0; i < 1024; i++) ram_mem[i] = 8'($urandom);
        for (int t = 0; t < 6; t++) begin
            ready_mode = t % 2;
            rl = $urandom_range(1, 96);
            applyStimulus(10'($urandom_range(0, 1023)), 11'(rl));
            waitDone("rand_done");
            settle(1);
            checkOutput("rand_bytes", 32'(hs_count), 32'(rl));
        end
        ready_mode = 0;
        settle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
